// File: rtl/grid_mem_responder_if.sv
// Gameplay-side request/response bundle for one grid_mem_responder board.
interface grid_mem_responder_if #(
    parameter int AW = 7
);
    logic [AW-1:0] addr;
    logic [1:0]    wdata;
    logic          we;
    logic          oe;
    logic [1:0]    rdata;
    logic          rvalid;
    logic          err;
    logic          busy;

    modport master (
        output addr, wdata, we, oe,
        input  rdata, rvalid, err, busy
    );

    modport slave (
        input  addr, wdata, we, oe,
        output rdata, rvalid, err, busy
    );
endinterface

// File: rtl/grid_mem_responder.sv
// One 10x10 Battleship board: 2-bit cells, self-clearing sweep, live ship/hit
// counts for win detection, plus a read-only registered scan port for video.
module grid_mem_responder #(
    parameter int CELLS = 100,
    parameter int AW    = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    grid_mem_responder_if.slave        bus,
    input  logic [AW-1:0]              scan_addr_i,
    output logic [1:0]                 scan_data_o,
    input  logic                       clear_req_i,
    output logic [6:0]                 ship_cnt_o,
    output logic [6:0]                 hit_cnt_o,
    output logic                       all_sunk_o,
    output logic                       state_o
);
    // Handshake: we/oe are single-cycle requests, accepted when busy is low and
    // addr < CELLS; an accepted oe answers with rvalid+rdata on the next cycle,
    // a rejected we/oe answers with a one-cycle err pulse on the next cycle.
    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

    localparam logic [AW:0]   CELLS_W  = (AW+1)'(CELLS);
    localparam logic [AW-1:0] LAST_IDX = (AW)'(CELLS - 1);

    logic [1:0]    mem_q [CELLS];
    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [1:0]    rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    scan_q, scan_d;
    logic          err_q, err_d;
    logic [6:0]    ship_q, ship_d;
    logic [6:0]    hit_q, hit_d;
    logic          sunk_q, sunk_d;

    logic          busy;
    logic          addr_ok;
    logic          scan_ok;
    logic          accept_wr;
    logic          accept_rd;
    logic [1:0]    old_val;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [1:0]    wr_val;

    assign busy      = (state_q == ST_CLEAR);
    assign addr_ok   = ({1'b0, bus.addr} < CELLS_W);
    assign scan_ok   = ({1'b0, scan_addr_i} < CELLS_W);
    assign accept_wr = !busy && bus.we && addr_ok;
    assign accept_rd = !busy && bus.oe && addr_ok;
    assign old_val   = addr_ok ? mem_q[bus.addr] : 2'b00;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_en     = 1'b0;
        wr_idx    = bus.addr;
        wr_val    = bus.wdata;
        case (state_q)
            ST_CLEAR: begin
                if (clear_req_i) begin
                    clr_idx_d = '0;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = clr_idx_q;
                    wr_val = 2'b00;
                    if (clr_idx_q == LAST_IDX) begin
                        state_d   = ST_READY;
                        clr_idx_d = '0;
                    end else begin
                        clr_idx_d = clr_idx_q + (AW)'(1);
                    end
                end
            end
            ST_READY: begin
                wr_en = accept_wr;
                if (clear_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Bit 0 set means "ship present" (01 or 11); both bits set means "hit".
    always_comb begin
        ship_d = ship_q;
        hit_d  = hit_q;
        if (accept_wr) begin
            if (bus.wdata[0] && !old_val[0])      ship_d = ship_q + 7'd1;
            else if (!bus.wdata[0] && old_val[0]) ship_d = ship_q - 7'd1;
            if ((&bus.wdata) && !(&old_val))      hit_d = hit_q + 7'd1;
            else if (!(&bus.wdata) && (&old_val)) hit_d = hit_q - 7'd1;
        end
        if (clear_req_i || busy) begin
            ship_d = '0;
            hit_d  = '0;
        end
        sunk_d   = (ship_d != 7'd0) && (hit_d == ship_d);
        rdata_d  = accept_rd ? old_val : rdata_q;
        rvalid_d = accept_rd;
        err_d    = (bus.we || bus.oe) && (busy || !addr_ok);
        scan_d   = scan_ok ? mem_q[scan_addr_i] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            rdata_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            scan_q    <= 2'b00;
            err_q     <= 1'b0;
            ship_q    <= '0;
            hit_q     <= '0;
            sunk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            scan_q    <= scan_d;
            err_q     <= err_d;
            ship_q    <= ship_d;
            hit_q     <= hit_d;
            sunk_q    <= sunk_d;
        end
    end

    // Cell storage needs no reset: every reset leaves the FSM sweeping it to 00.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_val;
    end

    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy;
    assign scan_data_o = scan_q;
    assign ship_cnt_o  = ship_q;
    assign hit_cnt_o   = hit_q;
    assign all_sunk_o  = sunk_q;
    assign state_o     = (state_q == ST_READY);
endmodule

// File: tb/tb_grid_mem_responder.sv
// Directed bench for grid_mem_responder: reset sweep, placement, hits, win,
// read-first collisions, rejections and mid-sweep re-clear.
module tb_grid_mem_responder;
    logic       clk;
    logic       rst_n;
    logic [6:0] scan_addr;
    logic [1:0] scan_data;
    logic       clear_req;
    logic [6:0] ship_cnt;
    logic [6:0] hit_cnt;
    logic       all_sunk;
    logic       state_dbg;
    int         n_checks;
    int         n_pass;

    grid_mem_responder_if #(.AW(7)) dif ();

    grid_mem_responder #(.CELLS(100), .AW(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (dif),
        .scan_addr_i (scan_addr),
        .scan_data_o (scan_data),
        .clear_req_i (clear_req),
        .ship_cnt_o  (ship_cnt),
        .hit_cnt_o   (hit_cnt),
        .all_sunk_o  (all_sunk),
        .state_o     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_counts(input string tag, input logic [6:0] s, input logic [6:0] h,
                                input logic a);
        check({tag, "_ship"}, 8'(ship_cnt), 8'(s));
        check({tag, "_hit"},  8'(hit_cnt),  8'(h));
        check({tag, "_sunk"}, 8'(all_sunk), 8'(a));
    endtask

    task automatic write_cell(input logic [6:0] a, input logic [1:0] v);
        dif.we = 1'b1; dif.addr = a; dif.wdata = v;
        tick();
        dif.we = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; clear_req = 1'b0; scan_addr = '0;
        dif.addr = '0; dif.wdata = '0; dif.we = 1'b0; dif.oe = 1'b0;

        tick();
        tick();
        check("rst_busy",   8'(dif.busy),   8'd1);
        check("rst_rvalid", 8'(dif.rvalid), 8'd0);
        check("rst_rdata",  8'(dif.rdata),  8'd0);
        check("rst_scan",   8'(scan_data),  8'd0);
        check("rst_err",    8'(dif.err),    8'd0);
        check("rst_state",  8'(state_dbg),  8'd0);
        check_counts("rst", 7'd0, 7'd0, 1'b0);

        // First sweep; a write attempted mid-sweep must be rejected.
        rst_n = 1'b1;
        for (int i = 1; i <= 99; i++) begin
            if (i == 11) begin dif.we = 1'b1; dif.addr = 7'd3; dif.wdata = 2'b01; end
            tick();
            check("sweep_busy", 8'(dif.busy), 8'd1);
            if (i == 11) begin
                check("busy_we_err", 8'(dif.err), 8'd1);
                dif.we = 1'b0;
            end
        end
        tick();
        check("sweep_done_busy",  8'(dif.busy),  8'd0);
        check("sweep_done_state", 8'(state_dbg), 8'd1);
        check_counts("idle", 7'd0, 7'd0, 1'b0);

        for (int a = 0; a < 100; a++) begin
            scan_addr = 7'(a);
            tick();
            check("scan_clear", 8'(scan_data), 8'd0);
        end

        // Ship placement on 0,1,2.
        write_cell(7'd0, 2'b01); check_counts("place0", 7'd1, 7'd0, 1'b0);
        write_cell(7'd1, 2'b01); check_counts("place1", 7'd2, 7'd0, 1'b0);
        write_cell(7'd2, 2'b01); check_counts("place2", 7'd3, 7'd0, 1'b0);

        dif.oe = 1'b1; dif.addr = 7'd1;
        tick();
        dif.oe = 1'b0;
        check("rd1_rvalid", 8'(dif.rvalid), 8'd1);
        check("rd1_rdata",  8'(dif.rdata),  8'd1);
        tick();
        check("rd1_rvalid_drop", 8'(dif.rvalid), 8'd0);
        check("rd1_rdata_hold",  8'(dif.rdata),  8'd1);

        // Hits to win.
        write_cell(7'd0, 2'b11); check_counts("hit0", 7'd3, 7'd1, 1'b0);
        write_cell(7'd1, 2'b11); check_counts("hit1", 7'd3, 7'd2, 1'b0);
        write_cell(7'd2, 2'b11); check_counts("hit2", 7'd3, 7'd3, 1'b1);
        write_cell(7'd2, 2'b10); check_counts("miss2", 7'd2, 7'd2, 1'b1);
        write_cell(7'd5, 2'b11); check_counts("hit5", 7'd3, 7'd3, 1'b1);

        // Read-first collision on cell 7 for both the oe port and the scan port.
        write_cell(7'd7, 2'b01); check_counts("place7", 7'd4, 7'd3, 1'b0);
        dif.we = 1'b1; dif.oe = 1'b1; dif.addr = 7'd7; dif.wdata = 2'b11; scan_addr = 7'd7;
        tick();
        dif.we = 1'b0;
        check("coll_rvalid", 8'(dif.rvalid), 8'd1);
        check("coll_rdata",  8'(dif.rdata),  8'd1);
        check("coll_scan",   8'(scan_data),  8'd1);
        check_counts("coll", 7'd4, 7'd4, 1'b1);
        tick();
        dif.oe = 1'b0;
        check("coll_reread", 8'(dif.rdata), 8'd3);
        check("coll_rescan", 8'(scan_data), 8'd3);

        // Rejections.
        dif.we = 1'b1; dif.addr = 7'd100; dif.wdata = 2'b01;
        tick();
        dif.we = 1'b0;
        check("oob_we_err", 8'(dif.err), 8'd1);
        check_counts("oob_we", 7'd4, 7'd4, 1'b1);
        dif.oe = 1'b1; dif.addr = 7'd127;
        tick();
        dif.oe = 1'b0;
        check("oob_oe_err",    8'(dif.err),    8'd1);
        check("oob_oe_rvalid", 8'(dif.rvalid), 8'd0);
        check("oob_oe_rdata",  8'(dif.rdata),  8'd3);
        scan_addr = 7'd120;
        tick();
        check("err_drop",  8'(dif.err),  8'd0);
        check("scan_oob",  8'(scan_data), 8'd0);

        // Read immediately after write to the same cell returns the new value.
        write_cell(7'd9, 2'b01);
        check_counts("place9", 7'd5, 7'd4, 1'b0);
        dif.oe = 1'b1; dif.addr = 7'd9;
        tick();
        dif.oe = 1'b0;
        check("raw_rdata", 8'(dif.rdata), 8'd1);

        // Clear a populated board, then restart the sweep halfway through.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy", 8'(dif.busy), 8'd1);
        check_counts("clr", 7'd0, 7'd0, 1'b0);
        for (int i = 0; i < 50; i++) tick();
        check("mid_busy", 8'(dif.busy), 8'd1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 1; i <= 99; i++) begin
            if (i == 40) begin dif.oe = 1'b1; dif.addr = 7'd9; end
            tick();
            check("resweep_busy", 8'(dif.busy), 8'd1);
            if (i == 40) begin
                check("busy_oe_err",    8'(dif.err),    8'd1);
                check("busy_oe_rvalid", 8'(dif.rvalid), 8'd0);
                dif.oe = 1'b0;
            end
        end
        tick();
        check("resweep_done", 8'(dif.busy), 8'd0);
        check_counts("recleared", 7'd0, 7'd0, 1'b0);

        for (int a = 0; a < 100; a++) begin
            scan_addr = 7'(a);
            tick();
            check("scan_recleared", 8'(scan_data), 8'd0);
        end
        dif.oe = 1'b1; dif.addr = 7'd7;
        tick();
        dif.oe = 1'b0;
        check("reread7_rvalid", 8'(dif.rvalid), 8'd1);
        check("reread7_rdata",  8'(dif.rdata),  8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/grid_mem_responder.md
# grid_mem_responder

Memory-side responder for one 10x10 Battleship board: it services the gameplay controller's address, data, write-enable and output-enable requests, and serves a second read-only port to the VGA scan logic. Each design instantiates two copies, one for the Place board and one for the Shoot board. The block self-clears after reset and on request. It keeps live ship and hit counts so gameplay can detect a won board without scanning memory.

## Interface
Parameters:
- `CELLS`, default 100: number of valid cells; addresses 0..CELLS-1.
- `AW`, default 7: address width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `addr` in AW: gameplay request address (cursor cell).
- `wdata` in 2: cell value to write. Encoding: 00 empty, 01 ship, 10 miss, 11 hit.
- `we` in 1: write request, one cycle per write.
- `oe` in 1: read request, one cycle per read.
- `rdata` out 2: registered read data for an `oe` request.
- `rvalid` out 1: one-cycle pulse qualifying `rdata`.
- `scan_addr` in AW: VGA scan cell address.
- `scan_data` out 2: registered cell value at `scan_addr`.
- `clear_req` in 1: one-cycle pulse that re-clears the board.
- `busy` out 1: clear sweep in progress; requests are ignored while high.
- `err` out 1: one-cycle pulse on a rejected request.
- `ship_cnt` out 7: number of cells holding 01 or 11.
- `hit_cnt` out 7: number of cells holding 11.
- `all_sunk` out 1: high when `ship_cnt` != 0 and `hit_cnt` == `ship_cnt`.

## Operation
- Storage is a CELLS x 2-bit register array. Reads are combinational internally and registered at the outputs.
- FSM has two states, CLEAR and READY.
  - `rst_n`=0 forces CLEAR with `clr_idx`=0.
  - A `clear_req` pulse in READY enters CLEAR with `clr_idx`=0.
  - A `clear_req` pulse in CLEAR restarts `clr_idx` at 0.
- CLEAR behaviour:
  - Writes 00 to cell `clr_idx` each cycle, then increments `clr_idx`.
  - On the cycle that writes cell CELLS-1, moves to READY.
  - `busy`=1 throughout CLEAR.
  - `ship_cnt` and `hit_cnt` are forced to 0 on entry to CLEAR.
- Write in READY: `we`=1 and `addr`<CELLS writes `wdata` to the cell at the clock edge.
  - Counters update on the same edge from the old/new value pair.
  - `ship_cnt` += (new∈{01,11}) − (old∈{01,11}).
  - `hit_cnt` += (new==11) − (old==11).
  - Counters never wrap; by construction they stay within 0..CELLS.
- Read in READY: `oe`=1 and `addr`<CELLS registers the cell value into `rdata` and pulses `rvalid` for one cycle.
- If `we` and `oe` are both high on the same cycle:
  - The write is performed.
  - `rdata` returns the old value (read-first).
- Rejected requests:
  - `addr`>=CELLS with `we` or `oe` high: no write, no `rvalid`, `err` pulses for one cycle.
  - `we` or `oe` high while `busy`=1: ignored, `err` pulses for one cycle.
- Scan port:
  - Each cycle, `scan_data` <= cell[`scan_addr`] when `scan_addr`<CELLS, else 00.
  - The scan port is active in both states; during CLEAR it shows in-progress contents.
  - If a write and a scan hit the same cell in one cycle, `scan_data` shows the old value (read-first).
- `rdata` holds its last value between reads.

## Timing
- Reset values, with `rst_n` low at an edge: `rdata`=00, `rvalid`=0, `scan_data`=00, `err`=0, `busy`=1, `ship_cnt`=0, `hit_cnt`=0, `all_sunk`=0, state CLEAR, `clr_idx`=0.
- Clear duration: exactly CELLS cycles.
  - `busy` is high on the first cycle after `rst_n` rises.
  - `busy` falls after CELLS edges, i.e. 100 cycles at default.
  - The first request is accepted on the cycle `busy` is first seen low.
- Reset or `clear_req` mid-sweep restarts the full CELLS-cycle sweep.
- Write latency:
  - The cell is updated at the edge where `we` is sampled.
  - `ship_cnt`, `hit_cnt` and `all_sunk` reflect the write one cycle after `we` is asserted.
  - `all_sunk` is registered, derived from the next-state counts.
- Read latency: `rvalid` and `rdata` appear one cycle after `oe` is sampled.
- Scan latency: one cycle.
- Throughput: one request per cycle, back-to-back. A read on the cycle after a write to the same address returns the new value.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, release -> `busy`=1 for 100 cycles, then 0. All counters are 0. Scanning addresses 0..99 returns 00.
- Ship placement:
  - Write 01 to addresses 0, 1, 2 on consecutive cycles -> `ship_cnt` reads 1, 2, 3 on successive cycles; `hit_cnt`=0; `all_sunk`=0.
  - `oe` at address 1 -> `rdata`=01 with `rvalid` one cycle later.
- Hits to win:
  - Write 11 to 0, 1, 2 -> `hit_cnt` reaches 3; `all_sunk` rises 1 cycle after the third write.
  - Overwrite address 2 with 10 -> `ship_cnt`=2, `hit_cnt`=2, `all_sunk` stays 1.
  - Write 11 to empty address 5 -> `ship_cnt`=3, `hit_cnt`=3.
- Simultaneous access:
  - `we` with `wdata`=11, `oe`, and `scan_addr`=`addr`=7 in one cycle, cell 7 previously 01 -> `rdata`=01 and `scan_data`=01.
  - Next-cycle read of 7 -> 11.
- Rejections:
  - `we` at `addr`=100 -> `err` pulse, counters unchanged.
  - `we` during a clear sweep (`busy`=1) -> `err` pulse, no write.
  - `scan_addr`=120 -> `scan_data`=00.
- Re-clear mid-sweep:
  - `clear_req` at cycle 50 of a sweep -> `busy` stays high 100 more cycles.
  - After populated-board `clear_req`: counters are 0 the next cycle, and all cells read 00 after the sweep.
